// File: rtl/vga_arb_pkg.sv
// Shared types and default screen geometry for the VGA pixel-write arbiter.
package vga_arb_pkg;

   localparam int DEF_H_RES = 160;
   localparam int DEF_V_RES = 120;

   typedef logic [7:0] xcoord_t;
   typedef logic [6:0] ycoord_t;
   typedef logic [2:0] colour_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } arb_state_t;

endpackage

// File: rtl/screen_sweep_counter.sv
// Raster x/y counter for the full-screen fill: x is the inner loop, y the outer.
module screen_sweep_counter
   import vga_arb_pkg::*;
#(
   parameter int H_RES = DEF_H_RES,
   parameter int V_RES = DEF_V_RES
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    clr_i,
   input  logic    en_i,
   output xcoord_t x_o,
   output ycoord_t y_o,
   output logic    last_o
);

   localparam xcoord_t X_MAX = xcoord_t'(H_RES - 1);
   localparam ycoord_t Y_MAX = ycoord_t'(V_RES - 1);

   xcoord_t x_q, x_d;
   ycoord_t y_q, y_d;
   logic    x_wrap;

   always_comb begin
      x_wrap = (x_q == X_MAX);
      x_d    = x_q;
      y_d    = y_q;
      if (clr_i) begin
         x_d = '0;
         y_d = '0;
      end else if (en_i) begin
         if (x_wrap) begin
            x_d = '0;
            y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = x_wrap && (y_q == Y_MAX);

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter pixel-write port between N_REQ producers and a clear engine.
// Define VGA_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module vga_plot_arbiter
   import vga_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int H_RES = DEF_H_RES,
   parameter int V_RES = DEF_V_RES
) (
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ-1:0][7:0] req_x,
   input  logic [N_REQ-1:0][6:0] req_y,
   input  logic [N_REQ-1:0][2:0] req_colour,
   output logic [N_REQ-1:0]      ack,
   input  logic                  clear_start,
   input  logic [2:0]            clear_colour,
   output logic                  clear_busy,
   output logic                  clear_done,
   output logic [7:0]            oX,
   output logic [6:0]            oY,
   output logic [2:0]            oColour,
   output logic                  oPlot
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_t       state_q, state_d;
   logic             done_q, done_d;
   colour_t          clr_col_q;
   logic             start_acc;
   logic             arb_en;
   logic             grant_vld;
   logic [IDX_W-1:0] grant_idx;
   logic             grant;
   logic             in_range;

   xcoord_t          sweep_x;
   ycoord_t          sweep_y;
   logic             sweep_last;

   xcoord_t          x_q, x_d;
   ycoord_t          y_q, y_d;
   colour_t          col_q, col_d;
   logic             plot_q, plot_d;

   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      start_acc = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear_start) begin
               start_acc = 1'b1;
               state_d   = CLEAR;
            end
         end
         CLEAR: begin
            if (sweep_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The cycle that shows the last fill pixel also holds off requesters.
   assign arb_en = (state_q == IDLE) && !clear_start && !done_q;
   assign grant  = arb_en && grant_vld;

`ifdef VGA_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_q, rr_d;

   always_comb begin
      int cand;
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = int'(rr_q) + i;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!grant_vld && req[cand]) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (grant) begin
         rr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) rr_q <= '0;
      else         rr_q <= rr_d;
   end
`else
   // Descending scan so the lowest requesting index is the last to assign.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
   end
`endif

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         ack[i] = iReset && grant && (grant_idx == IDX_W'(i));
      end
   end

   assign in_range = (int'(req_x[grant_idx]) < H_RES) && (int'(req_y[grant_idx]) < V_RES);

   screen_sweep_counter #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_sweep (
      .clk_i  (iClock),
      .rst_ni (iReset),
      .clr_i  (start_acc),
      .en_i   (state_q == CLEAR),
      .x_o    (sweep_x),
      .y_o    (sweep_y),
      .last_o (sweep_last)
   );

   // Out-of-range grants are consumed but leave the output stage untouched.
   always_comb begin
      plot_d = 1'b0;
      x_d    = x_q;
      y_d    = y_q;
      col_d  = col_q;
      if (state_q == CLEAR) begin
         plot_d = 1'b1;
         x_d    = sweep_x;
         y_d    = sweep_y;
         col_d  = clr_col_q;
      end else if (grant && in_range) begin
         plot_d = 1'b1;
         x_d    = req_x[grant_idx];
         y_d    = req_y[grant_idx];
         col_d  = req_colour[grant_idx];
      end
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         col_q   <= '0;
         plot_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         x_q     <= x_d;
         y_q     <= y_d;
         col_q   <= col_d;
         plot_q  <= plot_d;
      end
   end

   always_ff @(posedge iClock) begin
      if (start_acc) clr_col_q <= clear_colour;
   end

   assign clear_busy = (state_q == CLEAR) || done_q;
   assign clear_done = done_q;
   assign oX         = x_q;
   assign oY         = y_q;
   assign oColour    = col_q;
   assign oPlot      = plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: vector table plus clear and reset sequences.
module tb_vga_plot_arbiter;

   logic            iClock;
   logic            iReset;
   logic [3:0]      req;
   logic [3:0][7:0] req_x;
   logic [3:0][6:0] req_y;
   logic [3:0][2:0] req_colour;
   logic [3:0]      ack;
   logic            clear_start;
   logic [2:0]      clear_colour;
   logic            clear_busy;
   logic            clear_done;
   logic [7:0]      oX;
   logic [6:0]      oY;
   logic [2:0]      oColour;
   logic            oPlot;

   int checks   = 0;
   int failures = 0;

   vga_plot_arbiter #(.N_REQ(4), .H_RES(160), .V_RES(120)) dut (
      .iClock       (iClock),
      .iReset       (iReset),
      .req          (req),
      .req_x        (req_x),
      .req_y        (req_y),
      .req_colour   (req_colour),
      .ack          (ack),
      .clear_start  (clear_start),
      .clear_colour (clear_colour),
      .clear_busy   (clear_busy),
      .clear_done   (clear_done),
      .oX           (oX),
      .oY           (oY),
      .oColour      (oColour),
      .oPlot        (oPlot)
   );

   initial begin
      iClock = 1'b0;
      forever #5 iClock = ~iClock;
   end

   typedef struct packed {
      logic [3:0] rq;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic [3:0] e_ack;
      logic       e_plot;
      logic [7:0] e_x;
      logic [6:0] e_y;
      logic [2:0] e_c;
   } vec_t;

   vec_t vecs [9];

   task automatic step();
      @(posedge iClock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      iReset      = 1'b0;
      req         = '0;
      clear_start = 1'b0;
      repeat (2) step();
      iReset = 1'b1;
   endtask

   task automatic set_req_data(input int k, input logic [7:0] x, input logic [6:0] y,
                               input logic [2:0] c);
      req_x[k]      = x;
      req_y[k]      = y;
      req_colour[k] = c;
   endtask

   initial begin
      int plots, rast_err, ack_err, busy_err, done_cnt, done_k, p;
      logic [3:0] cur;
      int order [3];

      vecs[0] = '{4'b0000, 8'd0,   7'd0,   3'd0, 4'b0000, 1'b0, 8'd0,   7'd0,   3'd0};
      vecs[1] = '{4'b0100, 8'd10,  7'd20,  3'd2, 4'b0100, 1'b1, 8'd10,  7'd20,  3'd2};
      vecs[2] = '{4'b0000, 8'd0,   7'd0,   3'd0, 4'b0000, 1'b0, 8'd10,  7'd20,  3'd2};
      vecs[3] = '{4'b0010, 8'd160, 7'd5,   3'd7, 4'b0010, 1'b0, 8'd10,  7'd20,  3'd2};
      vecs[4] = '{4'b0010, 8'd159, 7'd119, 3'd5, 4'b0010, 1'b1, 8'd159, 7'd119, 3'd5};
      vecs[5] = '{4'b1000, 8'd5,   7'd120, 3'd4, 4'b1000, 1'b0, 8'd159, 7'd119, 3'd5};
      vecs[6] = '{4'b0001, 8'd0,   7'd0,   3'd1, 4'b0001, 1'b1, 8'd0,   7'd0,   3'd1};
      vecs[7] = '{4'b0001, 8'd1,   7'd1,   3'd3, 4'b0001, 1'b1, 8'd1,   7'd1,   3'd3};
      vecs[8] = '{4'b1000, 8'd159, 7'd0,   3'd6, 4'b1000, 1'b1, 8'd159, 7'd0,   3'd6};

      // Reset state, with every requester asserting to prove ack is gated.
      iReset       = 1'b0;
      clear_start  = 1'b0;
      clear_colour = 3'd0;
      req          = 4'b1111;
      for (int k = 0; k < 4; k++) set_req_data(k, 8'(k + 1), 7'(k + 1), 3'(k + 1));
      step();
      step();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_plot", 32'(oPlot), 32'd0);
      chk("rst_x", 32'(oX), 32'd0);
      chk("rst_y", 32'(oY), 32'd0);
      chk("rst_col", 32'(oColour), 32'd0);
      chk("rst_busy", 32'(clear_busy), 32'd0);
      chk("rst_done", 32'(clear_done), 32'd0);
      req    = '0;
      iReset = 1'b1;
      step();

      // Single-requester vectors: ack is combinational, outputs one edge later.
      for (int i = 0; i < 9; i++) begin
         req = vecs[i].rq;
         for (int k = 0; k < 4; k++) begin
            if (vecs[i].rq[k]) set_req_data(k, vecs[i].x, vecs[i].y, vecs[i].c);
            else               set_req_data(k, 8'hAA, 7'h55, 3'h7);
         end
         #1;
         chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].e_ack));
         step();
         chk($sformatf("vec%0d_plot", i), 32'(oPlot), 32'(vecs[i].e_plot));
         chk($sformatf("vec%0d_x", i), 32'(oX), 32'(vecs[i].e_x));
         chk($sformatf("vec%0d_y", i), 32'(oY), 32'(vecs[i].e_y));
         chk($sformatf("vec%0d_col", i), 32'(oColour), 32'(vecs[i].e_c));
      end
      req = '0;

      // Contention.
      do_reset();
      for (int k = 0; k < 4; k++) set_req_data(k, 8'(30 + k), 7'(40 + k), 3'(k));
`ifdef VGA_ARB_ROUND_ROBIN_EN
      req = 4'b1111;
      for (int n = 0; n < 8; n++) begin
         #1;
         chk($sformatf("rr%0d_ack", n), 32'(ack), 32'(4'b0001 << (n % 4)));
         step();
         chk($sformatf("rr%0d_plot", n), 32'(oPlot), 32'd1);
         chk($sformatf("rr%0d_x", n), 32'(oX), 32'(30 + (n % 4)));
      end
      req = '0;
`else
      order[0] = 0;
      order[1] = 1;
      order[2] = 3;
      cur = 4'b1011;
      req = cur;
      for (int n = 0; n < 3; n++) begin
         #1;
         chk($sformatf("fp%0d_ack", n), 32'(ack), 32'(4'b0001 << order[n]));
         step();
         cur[order[n]] = 1'b0;
         req = cur;
         chk($sformatf("fp%0d_plot", n), 32'(oPlot), 32'd1);
         chk($sformatf("fp%0d_x", n), 32'(oX), 32'(30 + order[n]));
         chk($sformatf("fp%0d_col", n), 32'(oColour), 32'(order[n]));
      end
`endif
      #1;
      chk("cont_end_ack", 32'(ack), 32'd0);
      step();
      chk("cont_end_plot", 32'(oPlot), 32'd0);

      // Full clear with a request held throughout.
      do_reset();
      set_req_data(0, 8'd1, 7'd2, 3'd3);
      req          = 4'b0001;
      clear_start  = 1'b1;
      clear_colour = 3'b110;
      #1;
      chk("clr_start_ack", 32'(ack), 32'd0);
      chk("clr_start_busy", 32'(clear_busy), 32'd0);
      step();
      clear_start  = 1'b0;
      clear_colour = 3'b000;
      plots = 0; rast_err = 0; ack_err = 0; busy_err = 0; done_cnt = 0; done_k = 0;
      for (int k = 1; k <= 19202; k++) begin
         #1;
         if (k <= 19201 && ack !== 4'b0000) ack_err++;
         if (k >= 2 && k <= 19201) begin
            p = k - 2;
            if (oPlot !== 1'b1 || oX !== 8'(p % 160) || oY !== 7'(p / 160) || oColour !== 3'b110)
               rast_err++;
         end
         if (oPlot === 1'b1) plots++;
         if (clear_done === 1'b1) begin
            done_cnt++;
            done_k = k;
         end
         if (clear_busy !== (k <= 19201)) busy_err++;
         if (k < 19202) step();
      end
      chk("clr_ack_blocked", 32'(ack_err), 32'd0);
      chk("clr_plot_count", 32'(plots), 32'd19200);
      chk("clr_raster", 32'(rast_err), 32'd0);
      chk("clr_busy", 32'(busy_err), 32'd0);
      chk("clr_done_count", 32'(done_cnt), 32'd1);
      chk("clr_done_cycle", 32'(done_k), 32'd19201);
      chk("clr_after_ack", 32'(ack), 32'b0001);
      step();
      req = '0;
      chk("clr_after_plot", 32'(oPlot), 32'd1);
      chk("clr_after_x", 32'(oX), 32'd1);
      chk("clr_after_y", 32'(oY), 32'd2);
      chk("clr_after_col", 32'(oColour), 32'd3);

      // Reset while pixel 5000 of a fill is on the outputs.
      do_reset();
      set_req_data(0, 8'd7, 7'd8, 3'd1);
      req          = 4'b0001;
      clear_start  = 1'b1;
      clear_colour = 3'b101;
      step();
      clear_start = 1'b0;
      done_cnt    = 0;
      for (int k = 1; k < 5002; k++) begin
         if (clear_done === 1'b1) done_cnt++;
         step();
      end
      chk("abort_pix_x", 32'(oX), 32'd40);
      chk("abort_pix_y", 32'(oY), 32'd31);
      iReset = 1'b0;
      #1;
      chk("abort_plot", 32'(oPlot), 32'd0);
      chk("abort_x", 32'(oX), 32'd0);
      chk("abort_y", 32'(oY), 32'd0);
      chk("abort_col", 32'(oColour), 32'd0);
      chk("abort_busy", 32'(clear_busy), 32'd0);
      chk("abort_ack", 32'(ack), 32'd0);
      repeat (3) step();
      iReset = 1'b1;
      #1;
      chk("abort_idle_ack", 32'(ack), 32'b0001);
      step();
      req = '0;
      chk("abort_req_plot", 32'(oPlot), 32'd1);
      chk("abort_req_x", 32'(oX), 32'd7);
      chk("abort_req_y", 32'(oY), 32'd8);
      busy_err = 0;
      for (int k = 0; k < 15000; k++) begin
         if (clear_done === 1'b1) done_cnt++;
         if (clear_busy !== 1'b0) busy_err++;
         step();
      end
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk("abort_no_busy", 32'(busy_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
